// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default thresholds, the count
// width helper and the wrap-around pointer increment for arbitrary depths.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_AE_LEVEL   = 2;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non-power-of-two depths use every entry.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer side signals of the synchronous FIFO; master drives
// requests, slave is the FIFO itself.
interface sync_fifo_ctrl_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
);

  localparam int CW = count_width(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl_fifo_ram.sv
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
// Kept separate so it can be swapped for a technology RAM macro.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, threshold flags and sticky
// error bits. Define SYNC_FIFO_FWFT_EN for first-word-fall-through output.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave bus
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  wa;
  logic                  ra;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wa    = bus.wr_en & ~full;
  assign ra    = bus.rd_en & ~empty;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wa),
    .waddr (wptr),
    .wdata (bus.data_in),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  // Error bits: a new violation outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wa) wptr <= AW'(ptr_next(32'(wptr), DEPTH));
      if (ra) rptr <= AW'(ptr_next(32'(rptr), DEPTH));
      case ({wa, ra})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      overflow_q  <= (bus.wr_en & full)  | (overflow_q  & ~bus.clr_err);
      underflow_q <= (bus.rd_en & empty) | (underflow_q & ~bus.clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = ram_rdata;
  assign bus.rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ra;
      if (ra) data_out_q <= ram_rdata;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Drives a depth-8 and a depth-5 FIFO with identical stimulus and checks both
// against a write/read-serial-number reference model every cycle.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic       clr_err;

  int tests_run = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(8)) if8 ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(5)) if5 ();

  assign if8.wr_en   = wr_en;
  assign if8.data_in = data_in;
  assign if8.rd_en   = rd_en;
  assign if8.clr_err = clr_err;
  assign if5.wr_en   = wr_en;
  assign if5.data_in = data_in;
  assign if5.rd_en   = rd_en;
  assign if5.clr_err = clr_err;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5.slave)
  );

  // Reference model: a FIFO is the sequence of accepted writes; the head is the
  // oldest write not yet matched by an accepted read.
  int         depth_of [2] = '{8, 5};
  int         af_of    [2] = '{6, 3};
  int         ae_of    [2] = '{2, 2};
  int         wn       [2];
  int         rn       [2];
  logic [7:0] hist     [2][4096];
  bit         ov       [2];
  bit         un       [2];
  logic [7:0] exp_data [2];
  bit         exp_valid[2];

  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      int  cnt;
      bit  is_full, is_empty, acc_w, acc_r;
      cnt      = wn[d] - rn[d];
      is_full  = (cnt == depth_of[d]);
      is_empty = (cnt == 0);
      acc_w    = wr_en && !is_full;
      acc_r    = rd_en && !is_empty;
      if (rst) begin
        wn[d] = 0; rn[d] = 0; ov[d] = 0; un[d] = 0;
        exp_data[d] = 8'h00; exp_valid[d] = 0;
      end else begin
        ov[d] = (wr_en && is_full) || (ov[d] && !clr_err);
        un[d] = (rd_en && is_empty) || (un[d] && !clr_err);
        exp_valid[d] = acc_r;
        if (acc_r) exp_data[d] = hist[d][rn[d] % 4096];
        if (acc_w) begin
          hist[d][wn[d] % 4096] = data_in;
          wn[d]++;
        end
        if (acc_r) rn[d]++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int d, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      fail_count++;
      $error("[TB] FAIL %s depth%0d: observed %0h expected %0h", tag, depth_of[d], obs, exp);
    end
  endtask

  task automatic checkDut(input int d, input logic [7:0] dout, input logic rv,
                          input logic fl, input logic em, input logic afl,
                          input logic ael, input logic [31:0] cnt_obs,
                          input logic ovf, input logic unf);
    int cnt;
    cnt = wn[d] - rn[d];
    checkOutput("count", d, cnt_obs, 32'(cnt));
    checkOutput("full", d, 32'(fl), 32'(cnt == depth_of[d]));
    checkOutput("empty", d, 32'(em), 32'(cnt == 0));
    checkOutput("almost_full", d, 32'(afl), 32'(cnt >= af_of[d]));
    checkOutput("almost_empty", d, 32'(ael), 32'(cnt <= ae_of[d]));
    checkOutput("overflow", d, 32'(ovf), 32'(ov[d]));
    checkOutput("underflow", d, 32'(unf), 32'(un[d]));
`ifdef SYNC_FIFO_FWFT_EN
    checkOutput("rd_valid", d, 32'(rv), 32'(cnt != 0));
    if (cnt != 0) checkOutput("data_out", d, 32'(dout), 32'(hist[d][rn[d] % 4096]));
`else
    checkOutput("rd_valid", d, 32'(rv), 32'(exp_valid[d]));
    checkOutput("data_out", d, 32'(dout), 32'(exp_data[d]));
`endif
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic rd,
                               input logic clr, input logic rs);
    wr_en = wr; data_in = din; rd_en = rd; clr_err = clr; rst = rs;
    @(posedge clk);
    modelStep();
    #1;
    checkDut(0, if8.data_out, if8.rd_valid, if8.full, if8.empty, if8.almost_full,
             if8.almost_empty, 32'(if8.count), if8.overflow, if8.underflow);
    checkDut(1, if5.data_out, if5.rd_valid, if5.full, if5.empty, if5.almost_full,
             if5.almost_empty, 32'(if5.count), if5.overflow, if5.underflow);
  endtask

  initial begin
    wr_en = 0; data_in = 0; rd_en = 0; clr_err = 0; rst = 1;
    #2;
    applyStimulus(0, 8'h00, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 1);

    // Fill past full: 9 writes 0x11..0x19.
    for (int i = 0; i < 9; i++) applyStimulus(1, 8'h11 + 8'(i), 0, 0, 0);
    // Drain past empty.
    for (int i = 0; i < 9; i++) applyStimulus(0, 8'h00, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 1, 0);

    // Streaming at count 4 across pointer wrap.
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h40 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 8'($urandom), 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 0);

    // Simultaneous requests when empty, then when full.
    applyStimulus(1, 8'h5A, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 8'h60 + 8'(i), 0, 0, 0);
    applyStimulus(1, 8'h77, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 1, 0);

    // Reset mid-write, then overflow concurrent with clear.
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h80 + 8'(i), 0, 0, 0);
    applyStimulus(1, 8'h90, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'hA0 + 8'(i), 0, 0, 0);
    applyStimulus(1, 8'hAF, 0, 1, 0);
    applyStimulus(0, 8'h00, 0, 1, 0);
    applyStimulus(0, 8'h00, 0, 0, 1);

    // Single word into empty, then pop it.
    applyStimulus(1, 8'hA5, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);

    // Random phases: write-heavy, balanced, read-heavy.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i < 200) ? 75 : (i < 400) ? 50 : 25;
      applyStimulus($urandom_range(0, 99) < wp, 8'($urandom),
                    $urandom_range(0, 99) < (100 - wp),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO, successor to the team's basic synchronous FIFO.
- Supports any depth, not only powers of two, and uses all DEPTH entries.
- Adds programmable almost-full/almost-empty flags, an occupancy count, a read-valid strobe and sticky overflow/underflow error flags.
- Sits between producer and consumer stages in the same clock domain; this is the standard buffering block for new datapaths.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 8, number of entries; legal range 2..1024, any integer
AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL; legal 1..DEPTH
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL; legal 0..DEPTH-1
CW (localparam), $clog2(DEPTH+1), width of count

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read request
data_out  out  DATA_WIDTH  read data
rd_valid  out  1  data_out updated by an accepted read this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  CW  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at posedge): wptr=0, rptr=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, and almost_full=(AF_LEVEL==0, i.e. 0). Memory contents are not reset.
- Reset dominates all other inputs. Reset mid-operation discards all stored data; the next cycle behaves as after power-up.
- Write accepted: wa = wr_en & ~full, with full sampled before the edge. Stores data_in at mem[wptr].
- Read accepted: ra = rd_en & ~empty. Loads mem[rptr] into data_out; rd_valid=1 the next cycle.
- Read latency is 1 cycle from the rd_en edge.
- data_out holds its value when no read is accepted; rd_valid=0 in that case.
- Pointer wrap: ptr <= (ptr==DEPTH-1) ? 0 : ptr+1. Never relies on natural binary overflow.
- count update: +1 on wa only, -1 on ra only, unchanged on both or neither. count is registered; all flags are combinational decodes of count.
- Simultaneous rd_en & wr_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: only the read is accepted and the write is dropped (overflow set).
  - Empty: only the write is accepted and the read is dropped (underflow set). The written word is not bypassed to data_out.
- overflow set on wr_en & full; underflow set on rd_en & empty. Both stay set until clr_err=1 or rst. If set and clear occur in the same cycle, set wins.
- No state machine; the state is (wptr, rptr, count, error bits).

Optional Feature:
Macro SYNC_FIFO_FWFT_EN enables first-word-fall-through mode.
- Defined:
  - data_out is driven combinationally from mem[rptr].
  - rd_valid = ~empty, so it is valid in the same cycle the word becomes available.
  - rd_en acts as an acknowledge that pops the head; the next word appears after the clock edge.
  - A write into an empty FIFO becomes visible on data_out one cycle after the write edge.
- Not defined: standard registered mode as described in Behaviour.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Shared package sync_fifo_pkg: the pointer-increment-with-wrap function, the CW width function, and the default threshold constants.
- One sub-module, fifo_ram: simple dual-port memory with synchronous write and an async read address port, DATA_WIDTH x DEPTH. Suitable for later replacement by a technology RAM.

Test Plan:
1. Reset, then 8 writes (0x11..0x18) with DEPTH=8, no reads -> full=1 after the 8th edge, count=8, almost_full=1 from count=6; 9th write sets overflow=1 and count stays 8.
2. From full, 8 reads -> data_out 0x11..0x18 in order with rd_valid pulsing the cycle after each rd_en; empty=1 at the end; a 9th read sets underflow=1 and data_out holds 0x18.
3. Simultaneous rd_en & wr_en at count=4 for 20 cycles -> count stays 4 and data order is preserved across pointer wrap; also run DEPTH=5 and check wrap 4 -> 0.
4. Simultaneous rd_en & wr_en when empty -> count=1, rd_valid=0, underflow=1; when full -> count=7, overflow=1.
5. rst asserted at count=5 during a write -> next cycle count=0, empty=1, data_out=0; clr_err=1 clears sticky bits, and clr_err concurrent with an overflow keeps overflow=1.
6. With SYNC_FIFO_FWFT_EN, write 0xA5 into empty -> next cycle rd_valid=1 and data_out=0xA5 without rd_en; rd_en=1 -> empty=1 next cycle.
